// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : 256 x 8 byte-addressed data RAM for the load/store path.
//                Synchronous write, combinational read gated by MemRead,
//                asynchronous reset that clears the entire array.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] DataAddress,
    input  logic [DATA_WIDTH-1:0] DataMemIn,
    output logic [DATA_WIDTH-1:0] DataMemOut
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Plain unpacked array so a bench can preload it hierarchically.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_readEn;

    // Reset clears every word at once, so each location is a resettable flop.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (MemWrite) begin
            r_mem[DataAddress] <= DataMemIn;
        end
    end

    // Output is forced to a clean zero whenever the read is not enabled.
    assign w_readEn   = MemRead && !Reset;
    assign DataMemOut = w_readEn ? r_mem[DataAddress] : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    logic       CLK;
    logic       Reset;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] DataAddress;
    logic [7:0] DataMemIn;
    logic [7:0] DataMemOut;

    int checks = 0;
    int errors = 0;

    // Reference contents: only written addresses are stored, all others are 0.
    logic [7:0] model [int];

    data_memory #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .DataAddress(DataAddress),
        .DataMemIn  (DataMemIn),
        .DataMemOut (DataMemOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] modelRead(input logic [7:0] addr);
        if (model.exists(int'(addr))) return model[int'(addr)];
        return 8'h00;
    endfunction

    always @(posedge Reset) model.delete();

    always @(posedge CLK) begin
        if (Reset === 1'b0 && MemWrite === 1'b1) model[int'(DataAddress)] = DataMemIn;
    end

    // Every falling edge: the output must equal what the rules imply.
    always @(negedge CLK) begin
        logic [7:0] exp;
        exp = (Reset !== 1'b0 || MemRead !== 1'b1) ? 8'h00 : modelRead(DataAddress);
        checks++;
        if (DataMemOut !== exp) begin
            errors++;
            $display("FAIL cycle_compare t=%0t addr=%02h got=%02h expected=%02h",
                     $time, DataAddress, DataMemOut, exp);
        end
    end

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (DataMemOut !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, DataMemOut, exp);
        end
    endtask

    task automatic checkModel(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] got;
        got = modelRead(addr);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s model got=%02h expected=%02h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] din);
        MemRead     = rd;
        MemWrite    = wr;
        DataAddress = addr;
        DataMemIn   = din;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        #1 check("rst_during_a00", 8'h00);
        tick(); tick();
        check("rst_held_a00", 8'h00);
        Reset = 1'b0;
        #1 check("rst_after_a00", 8'h00);
        tick();

        Reset = 1'b1;
        drive(1'b1, 1'b0, 8'hFF, 8'h00);
        #1 check("rst_during_aff", 8'h00);
        tick(); tick();
        Reset = 1'b0;
        #1 check("rst_after_aff", 8'h00);
        tick();

        // Write then read
        drive(1'b0, 1'b1, 8'h01, 8'h03);
        #1 check("write_out_zero", 8'h00);
        tick();
        drive(1'b1, 1'b0, 8'h01, 8'h00);
        #1 check("read_a01", 8'h03);
        DataAddress = 8'h00;
        #1 check("read_a00", 8'h00);
        tick();

        // Read gating
        drive(1'b0, 1'b0, 8'h01, 8'h00);
        #1 check("gate_off", 8'h00);
        MemRead = 1'b1;
        #1 check("gate_on", 8'h03);
        tick();

        // Boundaries and isolation
        drive(1'b0, 1'b1, 8'hFF, 8'hA5);
        tick();
        drive(1'b0, 1'b1, 8'h00, 8'h5A);
        tick();
        drive(1'b1, 1'b0, 8'hFF, 8'h00);
        #1 check("bound_aff", 8'hA5);
        DataAddress = 8'h00;
        #1 check("bound_a00", 8'h5A);
        DataAddress = 8'h01;
        #1 check("bound_a01", 8'h03);
        checkModel("model_aff", 8'hFF, 8'hA5);
        checkModel("model_a01", 8'h01, 8'h03);
        checkModel("model_a02", 8'h02, 8'h00);
        tick();

        // Read during write
        drive(1'b0, 1'b1, 8'h10, 8'h11);
        tick();
        drive(1'b1, 1'b1, 8'h10, 8'h22);
        #1 check("rdw_before", 8'h11);
        tick();
        check("rdw_after", 8'h22);
        MemWrite = 1'b0;
        tick();

        // Reset between edges with a write pending
        drive(1'b1, 1'b1, 8'h01, 8'h77);
        #1 check("mid_before", 8'h03);
        #1 Reset = 1'b1;
        #1 check("mid_async", 8'h00);
        tick();
        Reset    = 1'b0;
        MemWrite = 1'b0;
        #1 check("mid_after_a01", 8'h00);
        DataAddress = 8'hFF;
        #1 check("mid_after_aff", 8'h00);
        checkModel("model_cleared", 8'h01, 8'h00);
        tick();
        DataAddress = 8'h10;
        #1 check("mid_after_a10", 8'h00);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
